// File: rtl/rob_scoreboard_pkg.sv
// Shared types and default sizing for the reorder-buffer scoreboard.
package rob_scoreboard_pkg;

    localparam int unsigned WriteBackPorts   = 4;
    localparam int unsigned DefNrEntries     = 8;
    localparam int unsigned DefNrWbPorts     = WriteBackPorts;
    localparam int unsigned DefNrCommitPorts = 2;
    localparam int unsigned Xlen             = 32;

    typedef struct packed {
        logic            valid;
        logic            done;
        logic [4:0]      rd;
        logic [Xlen-1:0] pc;
        logic [Xlen-1:0] data;
    } rob_entry_t;

endpackage

// File: rtl/rob_fwd_lookup.sv
// Youngest-writer search for one source register, walking from head towards tail.
module rob_fwd_lookup
    import rob_scoreboard_pkg::*;
#(
    parameter int unsigned NR_ENTRIES  = DefNrEntries,
    parameter int unsigned NR_WB_PORTS = DefNrWbPorts,
    parameter int unsigned XLEN        = Xlen,
    parameter int unsigned TW          = $clog2(NR_ENTRIES)
) (
    input  logic [NR_ENTRIES-1:0]        ent_valid,
    input  logic [NR_ENTRIES-1:0]        ent_done,
    input  logic [NR_ENTRIES*5-1:0]      ent_rd,
    input  logic [NR_ENTRIES*XLEN-1:0]   ent_data,
    input  logic [TW-1:0]                head_idx,
    input  logic [4:0]                   rs_addr,
    input  logic [NR_WB_PORTS-1:0]       wb_valid,
    input  logic [NR_WB_PORTS*TW-1:0]    wb_tag,
    input  logic [NR_WB_PORTS*XLEN-1:0]  wb_data,
    output logic                         busy,
    output logic                         fwd_valid,
    output logic [XLEN-1:0]              fwd_data
);

    always_comb begin
        logic            hit;
        logic            wb_hit;
        logic [TW-1:0]   idx;
        logic [TW-1:0]   hit_idx;
        logic [XLEN-1:0] wb_val;
        hit     = 1'b0;
        hit_idx = '0;
        idx     = '0;
        wb_hit  = 1'b0;
        wb_val  = '0;
        // Later (younger) matches overwrite earlier ones.
        for (int unsigned k = 0; k < NR_ENTRIES; k++) begin
            idx = head_idx + TW'(k);
            if (ent_valid[idx] && ent_rd[5*idx +: 5] == rs_addr) begin
                hit     = 1'b1;
                hit_idx = idx;
            end
        end
        for (int p = int'(NR_WB_PORTS) - 1; p >= 0; p--) begin
            if (wb_valid[p] && wb_tag[p*TW +: TW] == hit_idx) begin
                wb_hit = 1'b1;
                wb_val = wb_data[p*XLEN +: XLEN];
            end
        end
        busy      = 1'b0;
        fwd_valid = 1'b0;
        fwd_data  = '0;
        if (rs_addr != 5'd0 && hit) begin
            if (ent_done[hit_idx]) begin
                fwd_valid = 1'b1;
                fwd_data  = ent_data[hit_idx*XLEN +: XLEN];
            end else if (wb_hit) begin
                fwd_valid = 1'b1;
                fwd_data  = wb_val;
            end else begin
                busy = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rob_scoreboard.sv
// In-order issue, out-of-order completion, in-order retire scoreboard with
// operand forwarding and whole-buffer flush.
module rob_scoreboard
    import rob_scoreboard_pkg::*;
#(
    parameter int unsigned NR_ENTRIES      = DefNrEntries,
    parameter int unsigned NR_WB_PORTS     = DefNrWbPorts,
    parameter int unsigned NR_COMMIT_PORTS = DefNrCommitPorts,
    parameter int unsigned XLEN            = Xlen,
    parameter int unsigned TW              = $clog2(NR_ENTRIES)
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            flush,
    input  logic                            issue_valid,
    output logic                            issue_ready,
    input  logic [4:0]                      issue_rd,
    input  logic [XLEN-1:0]                 issue_pc,
    output logic [TW-1:0]                   issue_tag,
    input  logic [NR_WB_PORTS-1:0]          wb_valid,
    input  logic [NR_WB_PORTS*TW-1:0]       wb_tag,
    input  logic [NR_WB_PORTS*XLEN-1:0]     wb_data,
    input  logic [9:0]                      rs_addr,
    output logic [1:0]                      rs_busy,
    output logic [1:0]                      rs_fwd_valid,
    output logic [2*XLEN-1:0]               rs_fwd_data,
    output logic [NR_COMMIT_PORTS-1:0]      commit_valid,
    input  logic [NR_COMMIT_PORTS-1:0]      commit_ack,
    output logic [NR_COMMIT_PORTS*5-1:0]    commit_rd,
    output logic [NR_COMMIT_PORTS*XLEN-1:0] commit_data,
    output logic [NR_COMMIT_PORTS*XLEN-1:0] commit_pc,
    output logic [TW:0]                     occupancy
);

    rob_entry_t entries_q [NR_ENTRIES];
    rob_entry_t entries_d [NR_ENTRIES];
    logic [TW:0] head_q, head_d, tail_q, tail_d;
    logic        alive_q;
    logic [TW-1:0] head_idx, tail_idx;
    logic        full, issue_fire;
    logic [NR_COMMIT_PORTS-1:0] ack_eff;
    logic [TW:0] ack_cnt;

    logic [NR_ENTRIES-1:0]      ent_valid, ent_done;
    logic [NR_ENTRIES*5-1:0]    ent_rd;
    logic [NR_ENTRIES*XLEN-1:0] ent_data;

    assign head_idx    = head_q[TW-1:0];
    assign tail_idx    = tail_q[TW-1:0];
    assign full        = (head_idx == tail_idx) && (head_q[TW] != tail_q[TW]);
    // alive_q holds issue off until the first edge after reset release.
    assign issue_ready = alive_q && !full;
    assign issue_fire  = issue_valid && issue_ready;
    assign issue_tag   = tail_idx;
    assign occupancy   = tail_q - head_q;

    always_comb begin
        logic          prefix;
        logic          ack_run;
        logic [TW-1:0] idx;
        prefix       = 1'b1;
        ack_run      = 1'b1;
        idx          = '0;
        ack_cnt      = '0;
        ack_eff      = '0;
        commit_valid = '0;
        commit_rd    = '0;
        commit_data  = '0;
        commit_pc    = '0;
        for (int unsigned i = 0; i < NR_COMMIT_PORTS; i++) begin
            idx             = head_idx + TW'(i);
            prefix          = prefix & entries_q[idx].valid & entries_q[idx].done;
            ack_run         = ack_run & prefix & commit_ack[i];
            commit_valid[i] = prefix;
            ack_eff[i]      = ack_run;
            if (ack_run) begin
                ack_cnt = ack_cnt + (TW+1)'(1);
            end
            commit_rd[i*5 +: 5]      = entries_q[idx].rd;
            commit_data[i*XLEN +: XLEN] = entries_q[idx].data;
            commit_pc[i*XLEN +: XLEN]   = entries_q[idx].pc;
        end
    end

    always_comb begin
        logic [TW-1:0] t;
        entries_d = entries_q;
        head_d    = head_q + ack_cnt;
        tail_d    = tail_q;
        t         = '0;
        // Descending order so the lowest port index has the final say.
        for (int p = int'(NR_WB_PORTS) - 1; p >= 0; p--) begin
            t = wb_tag[p*TW +: TW];
            if (wb_valid[p] && entries_q[t].valid) begin
                entries_d[t].done = 1'b1;
                entries_d[t].data = wb_data[p*XLEN +: XLEN];
            end
        end
        for (int unsigned i = 0; i < NR_COMMIT_PORTS; i++) begin
            if (ack_eff[i]) begin
                t            = head_idx + TW'(i);
                entries_d[t] = '0;
            end
        end
        if (issue_fire) begin
            entries_d[tail_idx] = '{valid: 1'b1, done: 1'b0, rd: issue_rd, pc: issue_pc, data: '0};
            tail_d              = tail_q + (TW+1)'(1);
        end
        if (flush) begin
            for (int unsigned k = 0; k < NR_ENTRIES; k++) begin
                entries_d[k] = '0;
            end
            head_d = '0;
            tail_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned k = 0; k < NR_ENTRIES; k++) begin
                entries_q[k] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            alive_q <= 1'b0;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            alive_q   <= 1'b1;
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < NR_ENTRIES; k++) begin
            ent_valid[k]             = entries_q[k].valid;
            ent_done[k]              = entries_q[k].done;
            ent_rd[k*5 +: 5]         = entries_q[k].rd;
            ent_data[k*XLEN +: XLEN] = entries_q[k].data;
        end
    end

    for (genvar r = 0; r < 2; r++) begin : g_fwd
        rob_fwd_lookup #(
            .NR_ENTRIES  (NR_ENTRIES),
            .NR_WB_PORTS (NR_WB_PORTS),
            .XLEN        (XLEN),
            .TW          (TW)
        ) u_fwd (
            .ent_valid (ent_valid),
            .ent_done  (ent_done),
            .ent_rd    (ent_rd),
            .ent_data  (ent_data),
            .head_idx  (head_idx),
            .rs_addr   (rs_addr[r*5 +: 5]),
            .wb_valid  (wb_valid),
            .wb_tag    (wb_tag),
            .wb_data   (wb_data),
            .busy      (rs_busy[r]),
            .fwd_valid (rs_fwd_valid[r]),
            .fwd_data  (rs_fwd_data[r*XLEN +: XLEN])
        );
    end

endmodule

// File: tb/tb_rob_scoreboard.sv
// Self-checking bench: commit scoreboard queue, forwarding vector table and
// hand-written sequences for full/wrap, flush and asynchronous reset.
module tb_rob_scoreboard;

    logic        clock = 1'b0;
    logic        reset_n, flush, issue_valid, issue_ready;
    logic [4:0]  issue_rd;
    logic [31:0] issue_pc;
    logic [2:0]  issue_tag;
    logic [3:0]  wb_valid;
    logic [11:0] wb_tag;
    logic [127:0] wb_data;
    logic [9:0]  rs_addr;
    logic [1:0]  rs_busy, rs_fwd_valid;
    logic [63:0] rs_fwd_data;
    logic [1:0]  commit_valid, commit_ack;
    logic [9:0]  commit_rd;
    logic [63:0] commit_data, commit_pc;
    logic [3:0]  occupancy;

    rob_scoreboard dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .flush        (flush),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .issue_rd     (issue_rd),
        .issue_pc     (issue_pc),
        .issue_tag    (issue_tag),
        .wb_valid     (wb_valid),
        .wb_tag       (wb_tag),
        .wb_data      (wb_data),
        .rs_addr      (rs_addr),
        .rs_busy      (rs_busy),
        .rs_fwd_valid (rs_fwd_valid),
        .rs_fwd_data  (rs_fwd_data),
        .commit_valid (commit_valid),
        .commit_ack   (commit_ack),
        .commit_rd    (commit_rd),
        .commit_data  (commit_data),
        .commit_pc    (commit_pc),
        .occupancy    (occupancy)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  tag;
        logic [4:0]  rd;
        logic [31:0] pc;
    } sb_t;

    typedef struct {
        logic [4:0]  rs0;
        logic [4:0]  rs1;
        int          port;
        logic [2:0]  tag;
        logic [31:0] data;
        logic [1:0]  busy;
        logic [1:0]  fv;
        logic [31:0] fd0;
        logic [31:0] fd1;
    } fvec_t;

    sb_t         sb_q[$];
    logic [31:0] wbdata_m [8];
    int          tail_m = 0;
    int          occ_m  = 0;
    fvec_t       vt [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [31:0] pc);
        sb_t rec;
        issue_valid = 1'b1;
        issue_rd    = rd;
        issue_pc    = pc;
        #1;
        check("issue_ready", issue_ready, 1);
        check("issue_tag", issue_tag, tail_m % 8);
        cycle();
        issue_valid = 1'b0;
        rec.tag = 3'(tail_m % 8);
        rec.rd  = rd;
        rec.pc  = pc;
        sb_q.push_back(rec);
        tail_m++;
        occ_m++;
        check("occupancy after issue", occupancy, occ_m);
    endtask

    task automatic wb_set(input int port, input logic [2:0] tag, input logic [31:0] data);
        wb_valid[port]          = 1'b1;
        wb_tag[port*3 +: 3]     = tag;
        wb_data[port*32 +: 32]  = data;
    endtask

    task automatic wb_apply();
        for (int p = 0; p < 4; p++) begin
            if (wb_valid[p]) wbdata_m[wb_tag[p*3 +: 3]] = wb_data[p*32 +: 32];
        end
        cycle();
        wb_valid = '0;
    endtask

    task automatic retire(input int n, input bit do_issue, input logic [4:0] rd,
                          input logic [31:0] pc);
        sb_t rec;
        for (int i = 0; i < n; i++) begin
            rec = sb_q[i];
            check("commit_valid slot", commit_valid[i], 1);
            check("commit_rd", commit_rd[i*5 +: 5], rec.rd);
            check("commit_pc", commit_pc[i*32 +: 32], rec.pc);
            check("commit_data", commit_data[i*32 +: 32], wbdata_m[rec.tag]);
        end
        commit_ack = (n == 2) ? 2'b11 : 2'b01;
        if (do_issue) begin
            issue_valid = 1'b1;
            issue_rd    = rd;
            issue_pc    = pc;
            check("issue_ready with ack", issue_ready, 1);
            check("issue_tag with ack", issue_tag, tail_m % 8);
        end
        cycle();
        commit_ack  = '0;
        issue_valid = 1'b0;
        repeat (n) void'(sb_q.pop_front());
        occ_m -= n;
        if (do_issue) begin
            rec.tag = 3'(tail_m % 8);
            rec.rd  = rd;
            rec.pc  = pc;
            sb_q.push_back(rec);
            tail_m++;
            occ_m++;
        end
        check("occupancy after retire", occupancy, occ_m);
    endtask

    // Two ports naming the same tag in one cycle is a stimulus protocol violation.
    always @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            for (int j = i + 1; j < 4; j++) begin
                if (wb_valid[i] && wb_valid[j] && wb_tag[i*3 +: 3] == wb_tag[j*3 +: 3]) begin
                    errors++;
                    $display("FAIL wb protocol: ports %0d and %0d share tag %0d", i, j,
                             wb_tag[i*3 +: 3]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [4:0] rd_tab [8];
        rd_tab = '{5'd1, 5'd2, 5'd3, 5'd5, 5'd7, 5'd7, 5'd9, 5'd0};
        // {rs0, rs1, port, tag, data, busy, fwd_valid, fwd_data0, fwd_data1}
        vt[0] = '{5'd5, 5'd0, -1, 3'd0, 32'h0, 2'b01, 2'b00, 32'h0, 32'h0};
        vt[1] = '{5'd5, 5'd7, 2, 3'd3, 32'hDEAD, 2'b10, 2'b01, 32'hDEAD, 32'h0};
        vt[2] = '{5'd7, 5'd9, -1, 3'd0, 32'h0, 2'b01, 2'b10, 32'h0, 32'h6666_0006};
        vt[3] = '{5'd7, 5'd0, 3, 3'd5, 32'h77, 2'b00, 2'b01, 32'h77, 32'h0};
        vt[4] = '{5'd3, 5'd1, -1, 3'd0, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0};
        vt[5] = '{5'd9, 5'd7, 0, 3'd4, 32'h99, 2'b10, 2'b01, 32'h6666_0006, 32'h0};
        vt[6] = '{5'd0, 5'd5, 1, 3'd7, 32'hAB, 2'b10, 2'b00, 32'h0, 32'h0};

        reset_n     = 1'b0;
        flush       = 1'b0;
        issue_valid = 1'b0;
        issue_rd    = '0;
        issue_pc    = '0;
        wb_valid    = '0;
        wb_tag      = '0;
        wb_data     = '0;
        rs_addr     = '0;
        commit_ack  = '0;

        #12;
        check("reset issue_ready", issue_ready, 0);
        check("reset occupancy", occupancy, 0);
        check("reset commit_valid", commit_valid, 0);
        check("reset rs_busy", rs_busy, 0);
        check("reset rs_fwd_valid", rs_fwd_valid, 0);
        #11;
        reset_n = 1'b1;
        cycle();
        check("post-reset issue_ready", issue_ready, 1);
        check("post-reset occupancy", occupancy, 0);

        for (int i = 0; i < 8; i++) issue(rd_tab[i], 32'h1000 + 32'(4 * i));
        check("full issue_ready", issue_ready, 0);
        check("full occupancy", occupancy, 8);

        // Issue attempt while full and ack with nothing committable: both ignored.
        issue_valid = 1'b1;
        issue_rd    = 5'd31;
        commit_ack  = 2'b11;
        #1;
        check("full not ready", issue_ready, 0);
        cycle();
        issue_valid = 1'b0;
        commit_ack  = '0;
        check("full occupancy held", occupancy, 8);
        check("full tag held", issue_tag, 0);

        wb_set(0, 3'd2, 32'h2222_0002);
        wb_apply();
        check("commit_valid tag0 pending", commit_valid, 2'b00);
        wb_set(1, 3'd0, 32'h0000_AAAA);
        wb_apply();
        check("commit_valid tag1 blocks", commit_valid, 2'b01);
        wb_set(3, 3'd1, 32'h1111_0001);
        #1;
        check("commit_valid registered", commit_valid, 2'b01);
        wb_apply();
        check("commit_valid both", commit_valid, 2'b11);
        retire(2, 1'b0, 5'd0, 32'h0);
        check("commit_valid head2", commit_valid, 2'b01);
        commit_ack = 2'b10;
        cycle();
        commit_ack = '0;
        check("non-prefix ack ignored", occupancy, occ_m);
        retire(1, 1'b0, 5'd0, 32'h0);

        wb_set(0, 3'd4, 32'h4444_0004);
        wb_set(1, 3'd6, 32'h6666_0006);
        wb_apply();
        check("commit_valid tag3 pending", commit_valid, 2'b00);

        for (int v = 0; v < 7; v++) begin
            cycle();
            rs_addr  = {vt[v].rs1, vt[v].rs0};
            wb_valid = '0;
            if (vt[v].port >= 0) wb_set(vt[v].port, vt[v].tag, vt[v].data);
            #1;
            check($sformatf("fwd vec%0d busy", v), rs_busy, vt[v].busy);
            check($sformatf("fwd vec%0d fwd_valid", v), rs_fwd_valid, vt[v].fv);
            if (vt[v].fv[0]) check($sformatf("fwd vec%0d data0", v), rs_fwd_data[31:0], vt[v].fd0);
            if (vt[v].fv[1]) check($sformatf("fwd vec%0d data1", v), rs_fwd_data[63:32], vt[v].fd1);
            wb_valid = '0;
        end
        rs_addr = '0;

        wb_set(0, 3'd3, 32'h3333_0003);
        wb_set(1, 3'd5, 32'h5555_0005);
        wb_set(2, 3'd7, 32'h7777_0007);
        wb_apply();
        check("commit_valid all done", commit_valid, 2'b11);
        retire(2, 1'b0, 5'd0, 32'h0);
        retire(1, 1'b0, 5'd0, 32'h0);
        check("commit_valid head6", commit_valid, 2'b11);

        for (int i = 0; i < 6; i++) issue(5'(10 + i), 32'h2000 + 32'(4 * i));
        check("refill full", issue_ready, 0);

        // Full with head at 6: ack two while issuing; the issue must stall.
        commit_ack  = 2'b11;
        issue_valid = 1'b1;
        issue_rd    = 5'd20;
        issue_pc    = 32'h3000;
        #1;
        check("full+ack not ready", issue_ready, 0);
        check("full+ack commit_valid", commit_valid, 2'b11);
        check("full+ack commit_pc0", commit_pc[31:0], sb_q[0].pc);
        cycle();
        commit_ack  = '0;
        issue_valid = 1'b0;
        repeat (2) void'(sb_q.pop_front());
        occ_m -= 2;
        check("full+ack occupancy", occupancy, occ_m);
        check("full+ack ready next", issue_ready, 1);
        check("full+ack tag held", issue_tag, 6);
        issue(5'd20, 32'h3000);
        issue(5'd21, 32'h3004);
        check("tail wrapped tag", issue_tag, 0);
        check("wrap full", issue_ready, 0);
        check("wrap occupancy", occupancy, 8);

        wb_set(0, 3'd0, 32'hF000_0000);
        wb_set(1, 3'd1, 32'hF000_0001);
        wb_set(2, 3'd2, 32'hF000_0002);
        wb_apply();
        retire(2, 1'b0, 5'd0, 32'h0);
        retire(1, 1'b1, 5'd22, 32'h3008);
        wb_set(0, 3'd3, 32'hF000_0003);
        wb_apply();
        rs_addr    = {5'd0, 5'd13};
        commit_ack = 2'b01;
        #1;
        check("acked entry forwards", rs_fwd_valid, 2'b01);
        check("acked entry data", rs_fwd_data[31:0], 32'hF000_0003);
        retire(1, 1'b0, 5'd0, 32'h0);
        check("pre-flush occupancy", occupancy, 5);

        flush       = 1'b1;
        issue_valid = 1'b1;
        issue_rd    = 5'd23;
        issue_pc    = 32'h3100;
        rs_addr     = {5'd0, 5'd14};
        wb_set(0, 3'd4, 32'hBAD);
        #1;
        check("flush cycle occupancy", occupancy, 5);
        check("flush cycle fwd", rs_fwd_data[31:0], 32'hBAD);
        cycle();
        flush       = 1'b0;
        issue_valid = 1'b0;
        wb_valid    = '0;
        sb_q.delete();
        tail_m = 0;
        occ_m  = 0;
        check("post-flush occupancy", occupancy, 0);
        check("post-flush commit_valid", commit_valid, 0);
        check("post-flush issue_tag", issue_tag, 0);
        check("post-flush ready", issue_ready, 1);
        check("post-flush rs_busy", rs_busy, 0);
        check("post-flush fwd_valid", rs_fwd_valid, 0);
        rs_addr = '0;

        issue(5'd3, 32'h4000);
        wb_set(0, 3'd0, 32'h4000_0040);
        wb_apply();
        check("post-flush commit_valid", commit_valid, 2'b01);
        retire(1, 1'b0, 5'd0, 32'h0);

        issue(5'd4, 32'h5000);
        issue(5'd5, 32'h5004);
        rs_addr = {5'd5, 5'd4};
        wb_set(0, 3'd1, 32'h5555_AAAA);
        #1;
        check("burst fwd_valid", rs_fwd_valid, 2'b01);
        check("burst busy", rs_busy, 2'b10);
        #2;
        reset_n = 1'b0;
        #1;
        check("async reset occupancy", occupancy, 0);
        check("async reset ready", issue_ready, 0);
        check("async reset commit_valid", commit_valid, 0);
        check("async reset busy", rs_busy, 0);
        check("async reset fwd_valid", rs_fwd_valid, 0);
        wb_valid = '0;
        #2;
        reset_n = 1'b1;
        sb_q.delete();
        tail_m = 0;
        occ_m  = 0;
        cycle();
        check("re-reset ready", issue_ready, 1);
        check("re-reset occupancy", occupancy, 0);
        check("re-reset tag", issue_tag, 0);

        // Simultaneous issue and ack at every fill level, wrapping both pointers.
        for (int k = 1; k < 8; k++) begin
            while (occ_m < k) issue(5'(k), 32'h6000 + 32'(16 * k + occ_m));
            wb_set(0, sb_q[0].tag, 32'h7000_0000 + 32'(k));
            wb_apply();
            retire(1, 1'b1, 5'(k + 8), 32'h6800 + 32'(k));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rob_scoreboard.md
Name: rob_scoreboard

Overview:
- Parametrised in-order-issue, out-of-order-completion, in-order-retire scoreboard for the OoO core.
- Generalises the single-entry issue/commit pairing to NR_ENTRIES in flight, NR_WB_PORTS completion ports and NR_COMMIT_PORTS retire ports.
- Adds operand forwarding lookup and whole-buffer flush on branch mispredict.
- Sits between decode/issue and the functional units; its commit outputs drive the GPR write and retire/trace logic.

Parameters:
- NR_ENTRIES, 8, buffer depth; power of two, at least 2.
- NR_WB_PORTS, 4, number of functional-unit writeback ports.
- NR_COMMIT_PORTS, 2, maximum retirements per cycle; between 1 and NR_ENTRIES.
- XLEN, 32, data and PC width.
- TW (derived), $clog2(NR_ENTRIES), tag width.

Ports:
- clock  in  1  core clock.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  mispredict flush; empties the buffer.
- issue_valid  in  1  decode presents an instruction.
- issue_ready  out  1  an entry is free.
- issue_rd  in  5  destination register; 0 means no write.
- issue_pc  in  XLEN  instruction PC.
- issue_tag  out  TW  tag allocated to the current issue (the tail index).
- wb_valid  in  NR_WB_PORTS  per-port completion strobe.
- wb_tag  in  NR_WB_PORTS×TW  completing tag, per port.
- wb_data  in  NR_WB_PORTS×XLEN  result, per port.
- rs_addr  in  2×5  source register addresses to look up.
- rs_busy  out  2  source is pending with no value available yet.
- rs_fwd_valid  out  2  rs_fwd_data is usable.
- rs_fwd_data  out  2×XLEN  forwarded value.
- commit_valid  out  NR_COMMIT_PORTS  entry head+i is retire-ready.
- commit_ack  in  NR_COMMIT_PORTS  consumer retires entry head+i.
- commit_rd  out  NR_COMMIT_PORTS×5  destination register per commit slot.
- commit_data  out  NR_COMMIT_PORTS×XLEN  result per commit slot.
- commit_pc  out  NR_COMMIT_PORTS×XLEN  PC per commit slot.
- occupancy  out  TW+1  number of valid entries.

Behaviour:
- Storage and pointers:
  - Circular buffer; each entry holds valid, done, rd, pc, data.
  - head and tail pointers are TW+1 bits; the MSB is the wrap bit.
  - empty when head==tail; full when indices are equal and wrap bits differ.
- Reset (reset_n low, asynchronous): clear all valid/done bits, head=tail=0.
  - While reset_n is low: issue_ready=0; commit_valid, rs_busy, rs_fwd_valid all 0; occupancy=0.
  - issue_ready rises in the first cycle after release.
- Issue:
  - issue_ready = !full, computed from registered state only.
  - A full buffer is not ready even if a commit happens in the same cycle.
  - On issue_valid&&issue_ready at the clock edge: write entry[tail] with valid=1, done=0, rd, pc; tail+1.
  - issue_tag = tail index at all times.
- Writeback:
  - For each port with wb_valid: if entry[wb_tag] is valid, set done=1 and data=wb_data.
  - Writeback to an invalid entry is ignored.
  - Duplicate tags in one cycle: the lowest port index wins. The bench flags this as a protocol error.
- Commit:
  - commit_valid[i]=1 iff entries head..head+i are all valid and done (prefix-contiguous).
  - commit_valid is driven from registered state only; a writeback in cycle N becomes committable in cycle N+1.
  - commit_ack must be a prefix of commit_valid. Acked entries are cleared and head advances by the ack count at the edge.
  - Ack without the matching valid is ignored.
- Occupancy: next = occupancy + issued − acked. Simultaneous issue and ack at every fill level is legal, including wrap-around of both pointers.
- Forwarding (per rs, combinational):
  - rs_addr==0: busy=0, fwd_valid=0.
  - Otherwise find the youngest valid entry with rd==rs_addr.
  - None found: busy=0, fwd_valid=0 (use the register file).
  - Found and done: fwd_valid=1 with the entry's data.
  - Found, not done, and a same-cycle wb port targets that tag: fwd_valid=1 with that wb_data, using lowest-port priority.
  - Otherwise busy=1.
  - Entries being acked this cycle still forward.
- Flush:
  - At the edge: clear all entries, head=tail=0.
  - Same-cycle issue, writeback and ack are discarded.
  - Outputs are combinationally unaffected in the flush cycle; issue_ready=1 in the next cycle.
- Reset mid-operation: asynchronous clear as above; in-flight writebacks are lost.

Decomposition:
- Shared package (OoO_pkg):
  - rob_entry_t struct (valid, done, rd, pc, data).
  - Default constants for NR_ENTRIES, NR_COMMIT_PORTS and NR_WB_PORTS (sized to WriteBackPorts).
- One natural sub-module: rob_fwd_lookup, the youngest-match priority search relative to head. It is instantiated once per rs port.

Test Plan:
- Reset then 8 issues with no writeback → issue_tag 0..7; issue_ready=0 after the 8th; occupancy=8.
- Issue tags 0,1,2; wb tag2 then tag0 → commit_valid=01 (tag1 blocks); wb tag1 → next cycle commit_valid=11; ack 11 → head=2, occupancy=1.
- Entry tag3 rd=x5 pending with rs_addr=x5 → rs_busy=1; same cycle wb port2 tag3 data 0xDEAD → rs_fwd_valid=1, data 0xDEAD, busy=0.
- Two in-flight writers to x7 (tags 4 and 5, only tag4 done, rs_addr=x7) → rs_busy=1 (youngest match wins).
- Full buffer with head at 6: ack 2 while issuing in the same cycle → issue stalls (ready=0); next cycle ready=1; tail wraps 7→0 with the wrap bit toggled.
- Flush asserted with 5 entries and a same-cycle issue plus wb → next cycle occupancy=0, commit_valid=0, issue_tag=0.
- reset_n pulsed low asynchronously mid-burst → outputs clear immediately without waiting for a clock edge.
